// File: rtl/eth_tx_pkt_arbiter_if.sv
// eth_tx_pkt_arbiter_if: AXI-Stream Ethernet frame channel (tdata/tuser/tlast/tvalid/tready)
interface eth_tx_pkt_arbiter_if #(
  parameter int EWIDTH = 512,
  parameter int UWIDTH = $clog2(EWIDTH/8)+1
);
  logic [EWIDTH-1:0] tdata;
  logic [UWIDTH-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  modport master(output tdata, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_tx_pkt_arbiter.sv
// eth_tx_pkt_arbiter: packet-atomic CHDR/CPU merge onto MAC TX with bounded CHDR bursts; ETH_TX_ARB_STATS_EN adds packet counters
module eth_tx_pkt_arbiter #(
  parameter int EWIDTH     = 512,
  parameter int UWIDTH     = $clog2(EWIDTH/8)+1,
  parameter int CHDR_BURST = 4
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  eth_tx_pkt_arbiter_if.slave  s0,
  eth_tx_pkt_arbiter_if.slave  s1,
  eth_tx_pkt_arbiter_if.master m,
  output logic [1:0]           cur_grant
`ifdef ETH_TX_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [31:0]          chdr_pkt_cnt,
  output logic [31:0]          cpu_pkt_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;
  localparam logic [3:0] BURST_MAX = 4'(CHDR_BURST);
  state_t            state, state_nxt;
  logic [3:0]        burst_cnt;
  logic [EWIDTH-1:0] tdata_sel;
  logic [UWIDTH-1:0] tuser_sel;
  logic              tlast_sel;
  logic              tvalid_sel;
  logic              done;
  // state register; reset lands in IDLE so every output drops to zero at once
  always_ff @(posedge bus_clk or negedge bus_rst_n)
    if (!bus_rst_n) state <= IDLE;
    else state <= state_nxt;
  // arbitration in IDLE, combinational pass-through of the granted port while passing
  always_comb begin
    state_nxt  = state;
    tdata_sel  = '0;
    tuser_sel  = '0;
    tlast_sel  = 1'b0;
    tvalid_sel = 1'b0;
    s0.tready  = 1'b0;
    s1.tready  = 1'b0;
    cur_grant  = 2'b00;
    done       = 1'b0;
    case (state)
      IDLE: state_nxt = (s0.tvalid && (!s1.tvalid || burst_cnt < BURST_MAX)) ? PASS0 :
                        s1.tvalid ? PASS1 : IDLE;
      PASS0: begin
        tdata_sel  = s0.tdata;
        tuser_sel  = s0.tuser;
        tlast_sel  = s0.tlast;
        tvalid_sel = s0.tvalid;
        s0.tready  = m.tready;
        cur_grant  = 2'b01;
        done       = s0.tvalid & m.tready & s0.tlast;
        state_nxt  = done ? IDLE : PASS0;
      end
      PASS1: begin
        tdata_sel  = s1.tdata;
        tuser_sel  = s1.tuser;
        tlast_sel  = s1.tlast;
        tvalid_sel = s1.tvalid;
        s1.tready  = m.tready;
        cur_grant  = 2'b10;
        done       = s1.tvalid & m.tready & s1.tlast;
        state_nxt  = done ? IDLE : PASS1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign m.tdata  = tdata_sel;
  assign m.tuser  = tuser_sel;
  assign m.tlast  = tlast_sel;
  assign m.tvalid = tvalid_sel;
  // consecutive CHDR grants, saturating; any CPU grant restarts the run
  always_ff @(posedge bus_clk or negedge bus_rst_n)
    if (!bus_rst_n) burst_cnt <= '0;
    else if (state == IDLE && state_nxt == PASS0) burst_cnt <= (burst_cnt < BURST_MAX) ? burst_cnt + 4'd1 : burst_cnt;
    else if (state == IDLE && state_nxt == PASS1) burst_cnt <= '0;
`ifdef ETH_TX_ARB_STATS_EN
  // forwarded-packet counters; clear wins over a same-cycle increment
  always_ff @(posedge bus_clk or negedge bus_rst_n)
    if (!bus_rst_n) begin
      chdr_pkt_cnt <= '0;
      cpu_pkt_cnt  <= '0;
    end else if (stats_clr) begin
      chdr_pkt_cnt <= '0;
      cpu_pkt_cnt  <= '0;
    end else begin
      if (done && state == PASS0) chdr_pkt_cnt <= chdr_pkt_cnt + 32'd1;
      if (done && state == PASS1) cpu_pkt_cnt <= cpu_pkt_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb_eth_tx_pkt_arbiter: randomized packet traffic against a packet-level scheduler model
module tb_eth_tx_pkt_arbiter;
  localparam int EWIDTH     = 512;
  localparam int UWIDTH     = $clog2(EWIDTH/8)+1;
  localparam int CHDR_BURST = 4;
  typedef struct packed {
    logic [EWIDTH-1:0] data;
    logic [UWIDTH-1:0] user;
    logic              last;
  } beat_t;
  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic [1:0]  cur_grant;
  logic        v [2];
  beat_t       bt [2];
  logic        m_rdy;
  beat_t       q [2][$];
  int          owner = -1;
  int          run = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          acc_beats = 0;
  int          vprob [2];
  int          rprob;
  logic [31:0] exp_cnt [2];
`ifdef ETH_TX_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] chdr_pkt_cnt;
  logic [31:0] cpu_pkt_cnt;
`endif
  eth_tx_pkt_arbiter_if #(.EWIDTH(EWIDTH), .UWIDTH(UWIDTH)) s0 ();
  eth_tx_pkt_arbiter_if #(.EWIDTH(EWIDTH), .UWIDTH(UWIDTH)) s1 ();
  eth_tx_pkt_arbiter_if #(.EWIDTH(EWIDTH), .UWIDTH(UWIDTH)) m ();
  assign s0.tdata  = bt[0].data;
  assign s0.tuser  = bt[0].user;
  assign s0.tlast  = bt[0].last;
  assign s0.tvalid = v[0];
  assign s1.tdata  = bt[1].data;
  assign s1.tuser  = bt[1].user;
  assign s1.tlast  = bt[1].last;
  assign s1.tvalid = v[1];
  assign m.tready  = m_rdy;
  eth_tx_pkt_arbiter #(.EWIDTH(EWIDTH), .UWIDTH(UWIDTH), .CHDR_BURST(CHDR_BURST)) dut (
    .bus_clk(bus_clk),
    .bus_rst_n(bus_rst_n),
    .s0(s0),
    .s1(s1),
    .m(m),
    .cur_grant(cur_grant)
`ifdef ETH_TX_ARB_STATS_EN
    ,
    .stats_clr(stats_clr),
    .chdr_pkt_cnt(chdr_pkt_cnt),
    .cpu_pkt_cnt(cpu_pkt_cnt)
`endif
  );
  always #5 bus_clk = ~bus_clk;
  task automatic check(input string tag, input logic [EWIDTH-1:0] got, input logic [EWIDTH-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_grant"}, EWIDTH'(cur_grant), EWIDTH'(2'b00));
    check({tag, "_m_tvalid"}, EWIDTH'(m.tvalid), EWIDTH'(1'b0));
    check({tag, "_m_tdata"}, m.tdata, '0);
    check({tag, "_m_tuser"}, EWIDTH'(m.tuser), '0);
    check({tag, "_m_tlast"}, EWIDTH'(m.tlast), EWIDTH'(1'b0));
    check({tag, "_s0_tready"}, EWIDTH'(s0.tready), EWIDTH'(1'b0));
    check({tag, "_s1_tready"}, EWIDTH'(s1.tready), EWIDTH'(1'b0));
  endtask
  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      for (int w = 0; w < EWIDTH/32; w++) b.data[w*32 +: 32] = $urandom;
      b.user = UWIDTH'($urandom);
      b.last = (k == len-1);
      q[p].push_back(b);
    end
  endtask
  task automatic cycle();
    beat_t eb;
    logic  ev;
    logic  hs;
    logic [1:0] eg;
    int    popped;
    popped = -1;
    @(negedge bus_clk);
    ev = (owner >= 0) ? v[owner] : 1'b0;
    eb = ev ? q[owner][0] : '0;
    eg = (owner < 0) ? 2'b00 : (owner == 0) ? 2'b01 : 2'b10;
    check("grant", EWIDTH'(cur_grant), EWIDTH'(eg));
    check("m_tvalid", EWIDTH'(m.tvalid), EWIDTH'(ev));
    check("m_tdata", m.tdata, eb.data);
    check("m_tuser", EWIDTH'(m.tuser), EWIDTH'(eb.user));
    check("m_tlast", EWIDTH'(m.tlast), EWIDTH'(eb.last));
    check("s0_tready", EWIDTH'(s0.tready), EWIDTH'(owner == 0 && m_rdy));
    check("s1_tready", EWIDTH'(s1.tready), EWIDTH'(owner == 1 && m_rdy));
    hs = ev && m_rdy;
    if (owner < 0) begin
      if (v[0] && (!v[1] || run < CHDR_BURST)) begin
        owner = 0;
        run = (run < CHDR_BURST) ? run + 1 : run;
      end else if (v[1]) begin
        owner = 1;
        run = 0;
      end
    end else if (hs) begin
      popped = owner;
      acc_beats++;
      void'(q[owner].pop_front());
      if (eb.last) begin
        exp_cnt[owner] = exp_cnt[owner] + 32'd1;
        owner = -1;
      end
    end
    @(posedge bus_clk);
    #1;
    if (popped >= 0) v[popped] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!v[i] && q[i].size() > 0 && int'($urandom_range(99)) < vprob[i]) v[i] = 1'b1;
      bt[i] = v[i] ? q[i][0] : '0;
    end
    m_rdy = int'($urandom_range(99)) < rprob;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || owner >= 0) && n < 5000) begin
      cycle();
      n++;
    end
    check("drain_left", EWIDTH'(q[0].size() + q[1].size()), '0);
  endtask
`ifdef ETH_TX_ARB_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_chdr_cnt"}, EWIDTH'(chdr_pkt_cnt), EWIDTH'(exp_cnt[0]));
    check({tag, "_cpu_cnt"}, EWIDTH'(cpu_pkt_cnt), EWIDTH'(exp_cnt[1]));
  endtask
`endif
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    v[0] = 1'b0;
    v[1] = 1'b0;
    bt[0] = '0;
    bt[1] = '0;
    m_rdy = 1'b0;
    vprob = '{100, 100};
    rprob = 100;
    exp_cnt = '{32'd0, 32'd0};
`ifdef ETH_TX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #3;
    check_idle("rst");
    @(posedge bus_clk);
    #1;
    bus_rst_n = 1'b1;
    m_rdy = 1'b1;
    add_pkt(0, 3);
    drain();
    add_pkt(0, 4);
    cycle();
    cycle();
    add_pkt(1, 2);
    drain();
    rprob = 50;
    add_pkt(1, 4);
    drain();
    rprob = 100;
    add_pkt(0, 5);
    acc_beats = 0;
    n = 0;
    while (acc_beats < 1 && n < 100) begin
      cycle();
      n++;
    end
    check("rst_wait", EWIDTH'(acc_beats), EWIDTH'(1));
    #1;
    bus_rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    owner = -1;
    run = 0;
    exp_cnt = '{32'd0, 32'd0};
    q[0].delete();
    q[1].delete();
    v[0] = 1'b0;
    v[1] = 1'b0;
    bt[0] = '0;
    bt[1] = '0;
    @(posedge bus_clk);
    #1;
    bus_rst_n = 1'b1;
    cycle();
    for (int k = 0; k < 10; k++) add_pkt(0, 1);
    for (int k = 0; k < 3; k++) add_pkt(1, 1);
    drain();
`ifdef ETH_TX_ARB_STATS_EN
    check("burst_chdr_cnt", EWIDTH'(chdr_pkt_cnt), EWIDTH'(10));
    check("burst_cpu_cnt", EWIDTH'(cpu_pkt_cnt), EWIDTH'(3));
    stats_clr = 1'b1;
    @(posedge bus_clk);
    #1;
    stats_clr = 1'b0;
    exp_cnt = '{32'd0, 32'd0};
    check_stats("clr");
`endif
    for (int r = 0; r < 6; r++) begin
      vprob[0] = int'($urandom_range(100, 20));
      vprob[1] = int'($urandom_range(100, 20));
      rprob = int'($urandom_range(100, 30));
      for (int k = 0; k < 6; k++) begin
        add_pkt(0, int'($urandom_range(5, 1)));
        add_pkt(1, int'($urandom_range(5, 1)));
      end
      drain();
`ifdef ETH_TX_ARB_STATS_EN
      check_stats("rand");
`endif
    end
    cycle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
